// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the round-robin adder arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } arb_state_e;

  localparam int unsigned ADDER_LATENCY = 2;

endpackage

// File: rtl/adder_valid_i.sv
// Two-stage unsigned adder: operands captured on valid_i, sum registered one cycle later.
module adder_valid_i #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH:0]   sum
);

  logic             stage1_valid;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  // Sum register only updates after a fresh capture, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage1_valid <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sum          <= '0;
    end else begin
      stage1_valid <= valid_i;
      if (valid_i) begin
        a_q <= data1;
        b_q <= data2;
      end
      if (stage1_valid) begin
        sum <= (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);
      end
    end
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among N_REQ requesters,
// one transaction in flight at a time.
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       s_valid,
  output logic [N_REQ-1:0]       s_ready,
  input  logic [N_REQ*WIDTH-1:0] s_data1,
  input  logic [N_REQ*WIDTH-1:0] s_data2,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH:0]         m_data,
  output logic [ID_W-1:0]        m_id
);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;
  logic             issue;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int unsigned cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      cand = (32'(last_grant) + off) % N_REQ;
      if (!grant_valid && s_valid[ID_W'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign op1 = s_data1[grant_idx*WIDTH +: WIDTH];
  assign op2 = s_data2[grant_idx*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = WAIT;
      WAIT:    state_next = OUT;
      OUT:     if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready is combinational to the current winner; gated during reset.
  always_comb begin
    s_ready = '0;
    issue   = 1'b0;
    if (!reset && state == IDLE && grant_valid) begin
      s_ready[grant_idx] = 1'b1;
      issue              = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid    <= 1'b0;
      m_id       <= '0;
      last_grant <= ID_W'(N_REQ - 1);
    end else begin
      m_valid <= (state_next == OUT);
      if (issue) begin
        m_id       <= grant_idx;
        last_grant <= grant_idx;
      end
    end
  end

  adder_valid_i #(
    .WIDTH (WIDTH)
  ) u_adder (
    .clk     (clk),
    .reset   (reset),
    .valid_i (issue),
    .data1   (op1),
    .data2   (op2),
    .sum     (m_data)
  );

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter with hand-computed expectations.
module tb_adder_rr_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned N_REQ = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_REQ-1:0]  s_valid;
  logic [N_REQ-1:0]  s_ready;
  logic [15:0]       s_data1;
  logic [15:0]       s_data2;
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH:0]    m_data;
  logic [1:0]        m_id;

  int errors = 0;
  int checks = 0;

  adder_rr_arbiter #(
    .WIDTH (WIDTH),
    .N_REQ (N_REQ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data1 (s_data1),
    .s_data2 (s_data2),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_id    (m_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [3:0] rr_sum [4];
    rr_sum[0] = 4'd1; rr_sum[1] = 4'd4; rr_sum[2] = 4'd7; rr_sum[3] = 4'd10;

    reset   = 1'b1;
    s_valid = 4'b1111;
    s_data1 = '0;
    s_data2 = '0;
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_id",    32'(m_id),    32'd0);
    chk("rst_m_data",  32'(m_data),  32'd0);
    s_valid = 4'b0000;
    reset   = 1'b0;
    tick();

    // Single request from requester 0: 4 + 1
    s_valid = 4'b0001; s_data1 = 16'h0004; s_data2 = 16'h0001;
    #1 chk("single_s_ready", 32'(s_ready), 32'h1);
    tick();
    s_valid = 4'b0000;
    #1 chk("single_wait_m_valid", 32'(m_valid), 32'd0);
    chk("single_wait_s_ready", 32'(s_ready), 32'd0);
    tick();
    chk("single_m_valid", 32'(m_valid), 32'd1);
    chk("single_m_data",  32'(m_data),  32'd5);
    chk("single_m_id",    32'(m_id),    32'd0);
    tick();
    chk("single_done", 32'(m_valid), 32'd0);

    // Overflow on requester 2: 15 + 15 = 30
    s_valid = 4'b0100; s_data1 = 16'h0F00; s_data2 = 16'h0F00;
    #1 chk("ovf_s_ready", 32'(s_ready), 32'h4);
    tick();
    s_valid = 4'b0000;
    tick();
    chk("ovf_m_valid", 32'(m_valid), 32'd1);
    chk("ovf_m_data",  32'(m_data),  32'h1E);
    chk("ovf_m_id",    32'(m_id),    32'd2);
    tick();

    // Fresh reset, then all four requesting continuously
    reset = 1'b1;
    tick();
    reset = 1'b0;
    s_data1 = 16'h4321; s_data2 = 16'h6420;
    s_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_s_ready", 32'(s_ready), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_wait_s_ready", 32'(s_ready), 32'd0);
      tick();
      chk("rr_out_s_ready", 32'(s_ready), 32'd0);
      chk("rr_m_valid", 32'(m_valid), 32'd1);
      chk("rr_m_id",    32'(m_id),    32'(k % 4));
      chk("rr_m_data",  32'(m_data),  32'(rr_sum[k % 4]));
      tick();
    end
    s_valid = 4'b0000;
    #1;

    // Backpressure on requester 1: 7 + 8
    m_ready = 1'b0;
    s_valid = 4'b0010; s_data1 = 16'h0070; s_data2 = 16'h0080;
    #1 chk("bp_s_ready", 32'(s_ready), 32'h2);
    tick();
    s_valid = 4'b0000;
    tick();
    chk("bp_m_valid0", 32'(m_valid), 32'd1);
    chk("bp_m_data0",  32'(m_data),  32'h0F);
    chk("bp_m_id0",    32'(m_id),    32'd1);
    s_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_hold_m_valid", 32'(m_valid), 32'd1);
      chk("bp_hold_m_data",  32'(m_data),  32'h0F);
      chk("bp_hold_m_id",    32'(m_id),    32'd1);
      chk("bp_hold_s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 4'b0000;
    m_ready = 1'b1;
    tick();
    chk("bp_release_m_valid", 32'(m_valid), 32'd0);
    s_valid = 4'b0001;
    #1 chk("bp_idle_s_ready", 32'(s_ready), 32'h1);
    tick();
    s_valid = 4'b0000;
    tick();
    chk("bp_next_m_id",   32'(m_id),   32'd0);
    chk("bp_next_m_data", 32'(m_data), 32'd0);
    tick();

    // Reset during WAIT after requester 1 handshake (9 + 3)
    s_valid = 4'b0010; s_data1 = 16'h0095; s_data2 = 16'h0032;
    #1 chk("rstw_s_ready", 32'(s_ready), 32'h2);
    tick();
    s_valid = 4'b0000;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("rstw_no_m_valid", 32'(m_valid), 32'd0);
      tick();
    end
    s_valid = 4'b0011;
    #1 chk("rstw_prio0_s_ready", 32'(s_ready), 32'h1);
    tick();
    s_valid = 4'b0000;
    tick();
    chk("rstw_m_valid", 32'(m_valid), 32'd1);
    chk("rstw_m_id",    32'(m_id),    32'd0);
    chk("rstw_m_data",  32'(m_data),  32'd7);
    tick();

    // Requester 3 asserts valid only while a transaction sits in WAIT
    for (int k = 0; k < 2; k++) begin
      s_valid = 4'b0001;
      #1 chk("pulse_s_ready_r0", 32'(s_ready), 32'h1);
      tick();
      s_valid = 4'b1000;
      #1 chk("pulse_wait_s_ready", 32'(s_ready), 32'd0);
      tick();
      s_valid = 4'b0000;
      chk("pulse_m_id", 32'(m_id), 32'd0);
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      chk("pulse_no_m_valid", 32'(m_valid), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  N_REQ  per-requester valid.
REQ-006 SHALL have port s_ready  output  N_REQ  per-requester ready.
REQ-007 SHALL have port s_data1  input  N_REQ*WIDTH  first operands; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port s_data2  input  N_REQ*WIDTH  second operands; same packing.
REQ-009 SHALL have port m_valid  output  1  result valid.
REQ-010 SHALL have port m_ready  input  1  downstream ready.
REQ-011 SHALL have port m_data  output  WIDTH+1  unsigned sum, carry in MSB.
REQ-012 SHALL have port m_id  output  clog2(N_REQ)  index of the requester owning m_data.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, OUT; exactly one transaction in flight.
REQ-014 In IDLE with any s_valid set, SHALL select one winner by round-robin, starting search at (last_grant+1) mod N_REQ.
REQ-015 In IDLE SHALL assert s_ready only for the winner, combinationally in the same cycle; all other s_ready bits 0.
REQ-016 s_ready SHALL be 0 in WAIT and OUT.
REQ-017 On handshake (IDLE, winner valid), SHALL pulse adder valid_i with the winner's operands, latch winner to m_id and last_grant, go IDLE->WAIT.
REQ-018 WAIT SHALL last exactly one cycle, then go to OUT.
REQ-019 In OUT SHALL drive m_valid=1, m_data=shared adder output, m_id stable.
REQ-020 m_valid SHALL rise exactly 2 cycles after the handshake cycle.
REQ-021 OUT with m_ready=1 SHALL complete the transfer and return to IDLE; m_valid=0 next cycle.
REQ-022 OUT with m_ready=0 SHALL hold m_valid, m_data, m_id unchanged indefinitely.
REQ-023 SHALL perform unsigned addition only; m_data = data1 + data2, no wrap (WIDTH+1 result).
REQ-024 A requester dropping s_valid before handshake SHALL not be granted; no state change.
REQ-025 Minimum issue interval SHALL be 3 cycles (IDLE, WAIT, OUT).
REQ-026 Winner SHALL be fixed for the IDLE cycle; changes in other s_valid bits in the same cycle SHALL not affect it.

Reset
REQ-027 On reset SHALL go to IDLE; m_valid=0, s_ready=0, m_id=0, m_data=0.
REQ-028 On reset last_grant SHALL become N_REQ-1, so requester 0 has first priority.
REQ-029 Reset mid-transaction (WAIT or OUT) SHALL discard the in-flight result, with no m_valid pulse afterwards.
REQ-030 Reset SHALL also reset the shared adder instance.

Structure
REQ-031 Package adder_arb_pkg SHALL hold the FSM state typedef (IDLE/WAIT/OUT) and constant ADDER_LATENCY=2.
REQ-032 SHALL instantiate exactly one sub-module: adder_valid_i (WIDTH) as the shared datapath.
REQ-033 Round-robin selection and operand muxing SHALL be internal combinational logic.

Verification
REQ-034 Single: s_valid=0001, data1[0]=4, data2[0]=1 -> s_ready=0001 in the same cycle; 2 cycles later m_valid=1, m_data=5, m_id=0.
REQ-035 Overflow: WIDTH=4, requester 2 sends 15+15 -> m_data=30 (5'b11110), m_id=2.
REQ-036 All four hold s_valid=1111 continuously, m_ready=1 -> grants in order 0,1,2,3,0, one every 3 cycles.
REQ-037 Backpressure: m_ready=0 for 5 cycles in OUT -> m_valid, m_data, m_id held and s_ready=0000; IDLE one cycle after m_ready=1.
REQ-038 Reset asserted in WAIT after requester 1 handshake (9+3) -> no m_valid afterwards; next request with s_valid=0010 and 0001 both set grants requester 0.
REQ-039 Requester 3 pulses s_valid only in WAIT cycles -> never granted, no output.
